unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency backing memory between the instruction-fetch port and the load/store port of the 5-stage pipeline.
- Sequences each access as a request/acknowledge transaction.
- Returns read data to the winning port and drives per-port stall signals. The PC / IF-ID stall logic and the MEM-stage freeze consume these.
- Data port has priority. A starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width of both ports and backing memory
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants made while fetch is pending before fetch is forced to win (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high with stable if_addr until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle pulse: if_rdata valid, fetch complete
if_stall  out  1  if_req & ~if_valid (combinational)
dm_req  in  1  data request; held with stable dm_we/dm_addr/dm_wdata until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, registered
dm_valid  out  1  one-cycle pulse: data access complete
dm_stall  out  1  dm_req & ~dm_valid (combinational)
mem_req  out  1  backing-memory request, registered, held until mem_ack
mem_we  out  1  backing write enable, registered
mem_addr  out  ADDR_W  backing address, registered
mem_wdata  out  DATA_W  backing write data, registered
mem_rdata  in  DATA_W  backing read data, valid when mem_ack=1
mem_ack  in  1  backing completion, one cycle, earliest the first cycle mem_req=1

Behaviour:
- States: IDLE, ISSUE, RESP. Grant register gnt: 0 = IF, 1 = DM.
- Reset (reset=0, asynchronous) clears, without waiting for clk:
  - state = IDLE, gnt = 0, starvation counter = 0
  - mem_req / mem_we / mem_addr / mem_wdata = 0
  - if_rdata / dm_rdata = 0
  - if_valid / dm_valid = 0
- Reset mid-transaction abandons the access. mem_req drops immediately, and no valid pulse is issued afterwards.
- IDLE:
  - If neither request is pending, stay in IDLE.
  - Otherwise pick a winner, latch its address/we/wdata into the mem_* registers, set mem_req=1, and go to ISSUE.
  - Fetch always drives mem_we=0.
- Winner selection:
  - Only dm_req pending: DM wins.
  - Only if_req pending: IF wins.
  - Both pending: DM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- Starvation counter (4 bits, saturating at STARVE_LIMIT), updated at each IDLE grant:
  - DM granted while if_req=1: increment.
  - IF granted, or if_req=0: clear to 0.
- ISSUE:
  - Hold mem_* stable.
  - On mem_ack=1: mem_req=0; capture mem_rdata into the granted port's rdata on a load or fetch; go to RESP.
  - On a store, dm_rdata keeps its previous value.
- RESP:
  - Pulse the granted port's valid for exactly this cycle, then go to IDLE.
  - The other port's valid stays 0.
- Minimum latency with zero-wait memory (ack in the first ISSUE cycle): request sampled in IDLE at cycle n, valid at cycle n+2. Each additional ack wait cycle adds 1 cycle.
- Requesters may change or drop req on the edge that ends the valid cycle. IDLE samples the new request value.
- mem_ack outside ISSUE is ignored.
- Requests dropped before completion are protocol violations. Behaviour is undefined; no recovery is required.
- Address/data arithmetic: none; values pass through unchanged at full width.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - grant IDs: GNT_IF=1'b0, GNT_DM=1'b1
  - default STARVE_LIMIT
- One sub-module, mem_arb_priority, contains the winner selection and the starvation counter.
  - Inputs: clk, reset, if_req, dm_req, grant_strobe.
  - Outputs: winner, starve_cnt.

Test Plan:
- Reset: hold reset=0 with if_req=1, then release -> all outputs 0 while reset is low; first mem_req one cycle after release with mem_addr = if_addr.
- Single fetch: if_req=1, if_addr=0x00000010, mem_ack on the first ISSUE cycle with mem_rdata=0x00500093 -> if_valid pulses at cycle +2 with if_rdata=0x00500093; if_stall is high for 2 cycles.
- Store then load with 3 wait cycles: store dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1 held for 4 cycles, dm_valid one pulse, dm_rdata unchanged; then load 0x40 returning 0xDEADBEEF -> dm_rdata=0xDEADBEEF.
- Contention: if_req and dm_req both continuously high, STARVE_LIMIT=4 -> grant sequence DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Reset mid-transaction: assert reset during ISSUE -> mem_req falls asynchronously; after release no stale valid pulse; the next request completes normally.
- Spurious ack: mem_ack=1 while in IDLE -> no valid pulse and no state change.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
// Defines the FSM states, the grant IDs and the default starvation limit.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;
    localparam int          STARVE_W             = 4;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch and data requests, with a fetch-starvation
// counter that forces a fetch grant after STARVE_LIMIT back-to-back data grants.
module mem_arb_priority
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic                dm_req,
    input  logic                grant_strobe,
    output logic                winner,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic fetch_starved;

    assign fetch_starved = (starve_cnt == LIMIT);

    // Data wins by default; a starved fetch overrides it only under contention.
    always_comb begin
        winner = GNT_IF;
        if (dm_req && !(if_req && fetch_starved)) begin
            winner = GNT_DM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_strobe) begin
            if (winner == GNT_DM && if_req) begin
                if (!fetch_starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch port
// and the load/store port, returning registered data and per-port stalls.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_e          state, state_nxt;
    logic                gnt, gnt_nxt;
    logic                grant_strobe;
    logic                winner;
    logic [STARVE_W-1:0] starve_cnt;

    logic                mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt, dm_rdata_nxt;
    logic                if_valid_nxt, dm_valid_nxt;

    mem_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .grant_strobe(grant_strobe),
        .winner      (winner),
        .starve_cnt  (starve_cnt)
    );

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        grant_strobe  = 1'b0;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_valid_nxt  = 1'b0;
        dm_valid_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant_strobe = 1'b1;
                    gnt_nxt      = winner;
                    mem_req_nxt  = 1'b1;
                    state_nxt    = ISSUE;
                    if (winner == GNT_DM) begin
                        mem_we_nxt    = dm_we;
                        mem_addr_nxt  = dm_addr;
                        mem_wdata_nxt = dm_wdata;
                    end else begin
                        mem_we_nxt   = 1'b0;
                        mem_addr_nxt = if_addr;
                    end
                end
            end

            // Valid is registered here so it is high exactly during RESP.
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    state_nxt   = RESP;
                    if (gnt == GNT_IF) begin
                        if_rdata_nxt = mem_rdata;
                        if_valid_nxt = 1'b1;
                    end else begin
                        if (!mem_we) begin
                            dm_rdata_nxt = mem_rdata;
                        end
                        dm_valid_nxt = 1'b1;
                    end
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= GNT_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
            if_valid  <= if_valid_nxt;
            dm_valid  <= dm_valid_nxt;
        end
    end

    // The counter saturates, so it can never exceed the configured limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (starve_cnt <= STARVE_W'(STARVE_LIMIT));
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter with a behavioural
// variable-latency memory responder.
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          if_valid, if_stall, dm_valid, dm_stall;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .dm_stall (dm_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    typedef struct {
        logic        port;   // 0 = fetch, 1 = data
        logic [31:0] data;
        int          lat;    // cycles from request to valid, -1 = not checked
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_arr [logic [31:0]];
    int          errors     = 0;
    int          checks     = 0;
    int          ack_wait   = 0;
    int          wait_cnt   = 0;
    int          we_cycles  = 0;
    int          valid_seen = 0;
    bit          force_ack  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then play the memory responder.
    task automatic tick();
        @(negedge clk);
        if (mem_req && mem_we && mem_addr == 32'h40 && mem_wdata == 32'hDEADBEEF) we_cycles++;
        if (if_valid || dm_valid) valid_seen++;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
        end else if (mem_req) begin
            if (wait_cnt == ack_wait) begin
                mem_ack = 1'b1;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
            end else begin
                mem_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        int   n;
        bit   got;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            n   = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                tick();
                n++;
                if (if_valid || dm_valid) got = 1'b1;
            end
            checks++;
            assert (got) else begin
                errors++;
                $error("FAIL %s_timeout observed=no_valid expected=valid", tag);
            end
            if (got) begin
                chk({tag, "_port"}, 32'(dm_valid), 32'(e.port));
                chk({tag, "_both"}, 32'(if_valid & dm_valid), 32'h0);
                chk({tag, "_data"}, e.port ? dm_rdata : if_rdata, e.data);
                chk({tag, "_stall"}, 32'(e.port ? dm_stall : if_stall), 32'h0);
                if (e.lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(e.lat));
            end
        end
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp, input int lat);
        if_req  = 1'b1;
        if_addr = addr;
        sb.push_back('{1'b0, exp, lat});
        #1 chk({tag, "_stall_on"}, 32'(if_stall), 32'h1);
        wait_resp(tag);
        if_req = 1'b0;
        tick();
        chk({tag, "_pulse"}, 32'(if_valid), 32'h0);
    endtask

    task automatic do_data(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp, input int lat);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        sb.push_back('{1'b1, exp, lat});
        #1 chk({tag, "_stall_on"}, 32'(dm_stall), 32'h1);
        wait_resp(tag);
        dm_req = 1'b0;
        tick();
        chk({tag, "_pulse"}, 32'(dm_valid), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h10;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_arr[32'h10] = 32'h00500093;
        mem_arr[32'h14] = 32'h00A00113;

        // Reset held with a pending fetch
        #1 reset = 1'b0;
        #1;
        chk("rst_async_mem_req", 32'(mem_req), 32'h0);
        chk("rst_async_if_valid", 32'(if_valid), 32'h0);
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_valids", {30'b0, if_valid, dm_valid}, 32'h0);
        reset = 1'b1;
        sb.push_back('{1'b0, 32'h00500093, -1});
        tick();
        chk("rel_mem_req", 32'(mem_req), 32'h1);
        chk("rel_mem_addr", mem_addr, 32'h10);
        wait_resp("rel_fetch");
        if_req = 1'b0;
        tick();

        // Single zero-wait fetch
        ack_wait = 0;
        do_fetch("fetch", 32'h10, 32'h00500093, 2);

        // Store then load with three wait cycles
        ack_wait  = 3;
        we_cycles = 0;
        do_data("store", 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 5);
        chk("store_we_cycles", 32'(we_cycles), 32'd4);
        do_data("load", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5);

        ack_wait = 1;
        do_fetch("fetch_w1", 32'h14, 32'h00A00113, 3);

        // Contention: both held, data wins four times, then fetch
        ack_wait = 0;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h40;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 32'hDEADBEEF, -1});
            sb.push_back('{1'b0, 32'h00500093, -1});
        end
        for (int i = 0; i < 10; i++) wait_resp($sformatf("cont%0d", i));
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();

        // Reset in the middle of a long access
        ack_wait = 5;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        tick();
        tick();
        chk("mid_mem_req", 32'(mem_req), 32'h1);
        #2 reset = 1'b0;
        #1 chk("mid_async_mem_req", 32'(mem_req), 32'h0);
        if_req = 1'b0;
        tick();
        reset      = 1'b1;
        valid_seen = 0;
        repeat (6) tick();
        chk("mid_no_stale_valid", 32'(valid_seen), 32'h0);
        chk("mid_idle_mem_req", 32'(mem_req), 32'h0);
        ack_wait = 0;
        do_fetch("post_rst", 32'h14, 32'h00A00113, 2);

        // Spurious ack while idle
        force_ack  = 1'b1;
        valid_seen = 0;
        repeat (3) tick();
        force_ack = 1'b0;
        tick();
        chk("spur_no_valid", 32'(valid_seen), 32'h0);
        chk("spur_mem_req", 32'(mem_req), 32'h0);
        chk("spur_if_rdata", if_rdata, 32'h00A00113);
        do_fetch("after_spur", 32'h10, 32'h00500093, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
